mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MINI-MIPS core. Sequences FETCH/DECODE/EXEC/MEM/WB, using

---
 rtl/mips_multicycle_ctrl_if.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle for the MINI-MIPS multi-cycle core.
// The master side is the control FSM, and the slave side is the datapath it steers.
interface mips_multicycle_ctrl_if #(
  parameter int unsigned ALU_OP_W = 4
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                alu_zero;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_write;
  logic [1:0]          reg_dst;
  logic [1:0]          wb_src;
  logic                halted;
  logic                illegal;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b, alu_op,
           reg_write, reg_dst, wb_src, halted, illegal
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b, alu_op,
           reg_write, reg_dst, wb_src, halted, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for MINI-MIPS: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with absorbing HALT and TRAP states.
module mips_multicycle_ctrl #(
  parameter logic [5:0]  HALT_OPCODE = 6'h3F,
  parameter int unsigned ALU_OP_W    = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  mips_multicycle_ctrl_if.master   bus
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [ALU_OP_W-1:0] AluAdd = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] AluSub = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] AluAnd = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] AluOr  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] AluSlt = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] AluSll = ALU_OP_W'(5);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StHalt, StTrap
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] fn_q, fn_d;

  logic                mem_req, mem_we, iord, ir_write, pc_write, reg_write, halted, illegal;
  logic [1:0]          pc_src, alu_src_b, reg_dst, wb_src;
  logic [ALU_OP_W-1:0] alu_op;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OpRtype: return fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnSll, FnJr};
      OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ, OpJal: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_OP_W-1:0] funct_alu(input logic [5:0] fn);
    case (fn)
      FnSub:   return AluSub;
      FnAnd:   return AluAnd;
      FnOr:    return AluOr;
      FnSlt:   return AluSlt;
      FnSll:   return AluSll;
      default: return AluAdd;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= 6'h00;
      fn_q    <= 6'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = AluAdd;
    reg_write = 1'b0;
    reg_dst   = 2'd0;
    wb_src    = 2'd0;
    halted    = 1'b0;
    illegal   = 1'b0;
    // Outputs are held low while reset is asserted so an in-flight access drops at once.
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end
        end
        StDecode: begin
          op_d      = bus.opcode;
          fn_d      = bus.funct;
          alu_src_b = 2'd3;
          if (bus.opcode == HALT_OPCODE)             state_d = StHalt;
          else if (!is_legal(bus.opcode, bus.funct)) state_d = StTrap;
          else                                       state_d = StExec;
        end
        StExec: begin
          case (op_q)
            OpRtype: begin
              if (fn_q == FnJr) begin
                pc_src   = 2'd3;
                pc_write = 1'b1;
                state_d  = StFetch;
              end else begin
                alu_op  = funct_alu(fn_q);
                state_d = StWb;
              end
            end
            OpAddi: begin
              alu_src_b = 2'd2;
              state_d   = StWb;
            end
            OpLw, OpSw: begin
              alu_src_b = 2'd2;
              state_d   = StMem;
            end
            OpBeq, OpBne: begin
              alu_op   = AluSub;
              pc_src   = 2'd1;
              pc_write = (op_q == OpBeq) ? bus.alu_zero : !bus.alu_zero;
              state_d  = StFetch;
            end
            OpJ, OpJal: begin
              pc_src   = 2'd2;
              pc_write = 1'b1;
              if (op_q == OpJal) begin
                reg_write = 1'b1;
                reg_dst   = 2'd2;
                wb_src    = 2'd2;
              end
              state_d = StFetch;
            end
            default: state_d = StTrap;
          endcase
        end
        StMem: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (op_q == OpSw);
          if (bus.mem_ready) state_d = (op_q == OpSw) ? StFetch : StWb;
        end
        StWb: begin
          reg_write = 1'b1;
          if (op_q == OpRtype) reg_dst = 2'd1;
          if (op_q == OpLw)    wb_src  = 2'd1;
          state_d = StFetch;
        end
        StHalt:  halted  = 1'b1;
        StTrap:  illegal = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.iord      = iord;
  assign bus.ir_write  = ir_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_op    = alu_op;
  assign bus.reg_write = reg_write;
  assign bus.reg_dst   = reg_dst;
  assign bus.wb_src    = wb_src;
  assign bus.halted    = halted;
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues the expected control word for
// each cycle, and a negedge monitor pops and compares it against the DUT outputs.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       halted;
    logic       illegal;
  } ctl_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  string nm_q[$];
  ctl_t  exp_q[$];
  ctl_t  act;

  mips_multicycle_ctrl_if #(.ALU_OP_W(4)) bus ();

  mips_multicycle_ctrl #(.HALT_OPCODE(6'h3F), .ALU_OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.alu_src_b, bus.alu_op, bus.reg_write, bus.reg_dst, bus.wb_src,
                bus.halted, bus.illegal};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      string nm;
      ctl_t  e;
      nm = nm_q.pop_front();
      e  = exp_q.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", nm, act, e);
      end
    end
  end

  function automatic ctl_t c(input logic mreq, input logic mwe, input logic io, input logic irw,
                             input logic pcw, input logic [1:0] pcs, input logic [1:0] asb,
                             input logic [3:0] aop, input logic rw, input logic [1:0] rd,
                             input logic [1:0] ws, input logic h, input logic il);
    return {mreq, mwe, io, irw, pcw, pcs, asb, aop, rw, rd, ws, h, il};
  endfunction

  // Drive mem_ready for the coming cycle and queue what the outputs must be during it.
  task automatic cyc(input string nm, input logic rdy, input ctl_t e);
    bus.mem_ready = rdy;
    nm_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  ctl_t zero, f_wait, f_go, dec, ex_add, ex_sub, ex_imm, wb_r, wb_i, wb_lw, mem_rd, mem_wr;
  ctl_t br_t, br_n, ex_jal, ex_jr, st_halt, st_trap;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;

    //          req we io irw pcw pcs asb aop rw rd ws h il
    zero    = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    f_wait  = c(1, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    f_go    = c(1, 0, 0, 1, 1, 2'd0, 2'd1, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    dec     = c(0, 0, 0, 0, 0, 2'd0, 2'd3, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    ex_add  = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    ex_sub  = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd1, 0, 2'd0, 2'd0, 0, 0);
    ex_imm  = c(0, 0, 0, 0, 0, 2'd0, 2'd2, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    wb_r    = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 1, 2'd1, 2'd0, 0, 0);
    wb_i    = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 1, 2'd0, 2'd0, 0, 0);
    wb_lw   = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 1, 2'd0, 2'd1, 0, 0);
    mem_rd  = c(1, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    mem_wr  = c(1, 1, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    br_t    = c(0, 0, 0, 0, 1, 2'd1, 2'd0, 4'd1, 0, 2'd0, 2'd0, 0, 0);
    br_n    = c(0, 0, 0, 0, 0, 2'd1, 2'd0, 4'd1, 0, 2'd0, 2'd0, 0, 0);
    ex_jal  = c(0, 0, 0, 0, 1, 2'd2, 2'd0, 4'd0, 1, 2'd2, 2'd2, 0, 0);
    ex_jr   = c(0, 0, 0, 0, 1, 2'd3, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0);
    st_halt = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 1, 0);
    st_trap = c(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 2'd0, 0, 1);

    @(posedge clk);
    #1;
    cyc("reset_outputs", 1'b1, zero);
    rst_n = 1'b1;

    // add: 4 cycles; opcode input is scrambled in EXEC to check the DECODE latch.
    set_ir(6'h00, 6'h20);
    cyc("add_fetch", 1'b1, f_go);
    cyc("add_decode", 1'b0, dec);
    set_ir(6'h2B, 6'h22);
    cyc("add_exec", 1'b0, ex_add);
    cyc("add_wb", 1'b0, wb_r);

    // sub with one fetch wait cycle.
    set_ir(6'h00, 6'h22);
    cyc("sub_fetch_wait", 1'b0, f_wait);
    cyc("sub_fetch", 1'b1, f_go);
    cyc("sub_decode", 1'b0, dec);
    cyc("sub_exec", 1'b0, ex_sub);
    cyc("sub_wb", 1'b0, wb_r);

    // addi
    set_ir(6'h08, 6'h15);
    cyc("addi_fetch", 1'b1, f_go);
    cyc("addi_decode", 1'b0, dec);
    cyc("addi_exec", 1'b0, ex_imm);
    cyc("addi_wb", 1'b0, wb_i);

    // lw with three MEM wait cycles: 8 cycles total.
    set_ir(6'h23, 6'h00);
    cyc("lw_fetch", 1'b1, f_go);
    cyc("lw_decode", 1'b0, dec);
    cyc("lw_exec", 1'b0, ex_imm);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, mem_rd);
    cyc("lw_mem_done", 1'b1, mem_rd);
    cyc("lw_wb", 1'b0, wb_lw);

    // sw, zero wait
    set_ir(6'h2B, 6'h00);
    cyc("sw_fetch", 1'b1, f_go);
    cyc("sw_decode", 1'b0, dec);
    cyc("sw_exec", 1'b0, ex_imm);
    cyc("sw_mem", 1'b1, mem_wr);

    // beq / bne with both zero-flag values.
    for (int k = 0; k < 4; k++) begin
      set_ir((k < 2) ? 6'h04 : 6'h05, 6'h00);
      cyc("br_fetch", 1'b1, f_go);
      cyc("br_decode", 1'b0, dec);
      bus.alu_zero = (k % 2 == 0);
      cyc((k < 2) ? "beq_exec" : "bne_exec", 1'b0, ((k == 0) || (k == 3)) ? br_t : br_n);
      bus.alu_zero = 1'b0;
    end

    // jal then jr
    set_ir(6'h03, 6'h00);
    cyc("jal_fetch", 1'b1, f_go);
    cyc("jal_decode", 1'b0, dec);
    cyc("jal_exec", 1'b0, ex_jal);
    set_ir(6'h00, 6'h08);
    cyc("jr_fetch", 1'b1, f_go);
    cyc("jr_decode", 1'b0, dec);
    cyc("jr_exec", 1'b0, ex_jr);

    // HALT: absorbing regardless of mem_ready.
    set_ir(6'h3F, 6'h00);
    cyc("halt_fetch", 1'b1, f_go);
    cyc("halt_decode", 1'b0, dec);
    for (int i = 0; i < 20; i++) cyc("halt_hold", i[0], st_halt);
    rst_n = 1'b0;
    cyc("halt_reset", 1'b1, zero);
    rst_n = 1'b1;

    // Illegal opcode 0x11 traps.
    set_ir(6'h11, 6'h00);
    cyc("trap_fetch", 1'b1, f_go);
    cyc("trap_decode", 1'b0, dec);
    for (int i = 0; i < 3; i++) cyc("trap_hold", 1'b1, st_trap);
    rst_n = 1'b0;
    cyc("trap_reset", 1'b0, zero);
    rst_n = 1'b1;

    // Unsupported R-type funct 0x21 traps too.
    set_ir(6'h00, 6'h21);
    cyc("badfn_fetch", 1'b1, f_go);
    cyc("badfn_decode", 1'b0, dec);
    cyc("badfn_trap", 1'b0, st_trap);
    rst_n = 1'b0;
    cyc("badfn_reset", 1'b0, zero);
    rst_n = 1'b1;

    // Reset in the middle of an sw MEM access abandons it and restarts at FETCH.
    set_ir(6'h2B, 6'h00);
    cyc("swrst_fetch", 1'b1, f_go);
    cyc("swrst_decode", 1'b0, dec);
    cyc("swrst_exec", 1'b0, ex_imm);
    cyc("swrst_mem_wait", 1'b0, mem_wr);
    rst_n = 1'b0;
    cyc("swrst_in_reset", 1'b0, zero);
    rst_n = 1'b1;
    set_ir(6'h00, 6'h20);
    cyc("swrst_refetch_wait", 1'b0, f_wait);
    cyc("swrst_refetch", 1'b1, f_go);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
